gmii_xgmii_lane_packer: RTL and testbench

//  Single-clock packer from byte-wide GMII receive stream to LANES-wide XGMII-style words.
//  - Start (0xFB) is placed in lane 0; Terminate (0xFD) follows the last byte; unused lanes get Idle (0x07).
//  - Sits behind the GMII PHY-side sampler, in front of the 10G MAC receive path.
//  - The lane count and the maximum frame size are parameters.

---
 rtl/gmii_xgmii_lane_packer.sv | 203 ++++++++++++++++++++
 tb/tb_gmii_xgmii_lane_packer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/gmii_xgmii_lane_packer.sv
// GMII byte stream to LANES-wide XGMII word packer (Start/Terminate/Idle framing, oversize drop).
// Optional: define GMII_ER_EN to replace receive-error bytes with the 0xFE error character.

// state  | meaning
// S_IDLE | between frames; each cycle writes Idle into the current lane
// S_DATA | frame in progress; bytes pass through as data
// S_DROP | frame exceeded max length; each cycle writes 0xFE until dv falls
module gmii_xgmii_lane_packer #(
  parameter int LANES               = 4,
  parameter int FRAME_MAX_BIT_WIDTH = 11
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 gmii_dv,
  input  logic                 gmii_er,
  input  logic [7:0]           gmii_rxd,
  output logic                 xgmii_valid,
  output logic [LANES-1:0]     xgmii_rxc,
  output logic [8*LANES-1:0]   xgmii_rxd,
  output logic [31:0]          frame_cnt,
  output logic                 oversize_err
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int FW = FRAME_MAX_BIT_WIDTH;

  localparam logic [7:0] CH_IDLE  = 8'h07;
  localparam logic [7:0] CH_START = 8'hFB;
  localparam logic [7:0] CH_TERM  = 8'hFD;
  localparam logic [7:0] CH_ERR   = 8'hFE;

  localparam logic [LW-1:0]      LANE_LAST  = LW'(LANES - 1);
  // count value one short of the limit: the byte that lands on the limit trips oversize
  localparam logic [FW-1:0]      BYTE_LAST  = FW'((2 ** FW) - 2);
  localparam logic [8*LANES-1:0] IDLE_WORD  = {LANES{CH_IDLE}};
  localparam logic [8*LANES-1:0] START_WORD = {{(LANES-1){CH_IDLE}}, CH_START};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [LW-1:0]      lane_cnt;
  logic [FW-1:0]      byte_cnt;
  logic [8*LANES-1:0] acc_rxd;
  logic [LANES-1:0]   acc_rxc;

  logic [7:0]         wr_byte;
  logic               wr_ctl;
  logic               sof;
  logic               term;
  logic               data_wr;
  logic               ovf;
  logic               hit_max;
  logic               byte_err;
  logic               sof_flush;
  logic               word_done;
  logic [8*LANES-1:0] merge_rxd;
  logic [LANES-1:0]   merge_rxc;

`ifdef GMII_ER_EN
  assign byte_err = gmii_er;
`else
  logic unused_gmii_er;
  assign unused_gmii_er = gmii_er;
  assign byte_err       = 1'b0;
`endif

  assign hit_max = (byte_cnt == BYTE_LAST);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (gmii_dv) state_nxt = S_DATA;
      S_DATA: begin
        if (!gmii_dv) begin
          state_nxt = S_IDLE;
        end else if (hit_max) begin
          state_nxt = S_DROP;
        end
      end
      S_DROP: if (!gmii_dv) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    wr_byte = CH_IDLE;
    wr_ctl  = 1'b1;
    sof     = 1'b0;
    term    = 1'b0;
    data_wr = 1'b0;
    ovf     = 1'b0;
    case (state)
      S_IDLE: begin
        if (gmii_dv) begin
          wr_byte = CH_START;
          sof     = 1'b1;
        end
      end
      S_DATA: begin
        if (gmii_dv) begin
          data_wr = 1'b1;
          ovf     = hit_max;
          if (byte_err) begin
            wr_byte = CH_ERR;
          end else begin
            wr_byte = gmii_rxd;
            wr_ctl  = 1'b0;
          end
        end else begin
          wr_byte = CH_TERM;
          term    = 1'b1;
        end
      end
      S_DROP: begin
        if (gmii_dv) begin
          wr_byte = CH_ERR;
        end else begin
          wr_byte = CH_TERM;
          term    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    merge_rxd = acc_rxd;
    merge_rxc = acc_rxc;
    for (int k = 0; k < LANES; k++) begin
      if (lane_cnt == LW'(k)) begin
        merge_rxd[8*k +: 8] = wr_byte;
        merge_rxc[k]        = wr_ctl;
      end
    end
  end

  // SOF always restarts at lane 0; a partially filled word is pushed out as-is
  assign sof_flush = sof && (lane_cnt != '0);
  assign word_done = !sof && (lane_cnt == LANE_LAST);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      lane_cnt     <= '0;
      byte_cnt     <= '0;
      acc_rxd      <= IDLE_WORD;
      acc_rxc      <= '1;
      xgmii_valid  <= 1'b0;
      xgmii_rxc    <= '1;
      xgmii_rxd    <= IDLE_WORD;
      frame_cnt    <= '0;
      oversize_err <= 1'b0;
    end else begin
      xgmii_valid  <= 1'b0;
      oversize_err <= ovf;

      if (term) begin
        frame_cnt <= frame_cnt + 32'd1;
      end

      if (sof) begin
        byte_cnt <= FW'(1);
      end else if (data_wr) begin
        byte_cnt <= byte_cnt + FW'(1);
      end

      if (sof) begin
        if (sof_flush) begin
          xgmii_valid <= 1'b1;
          xgmii_rxd   <= acc_rxd;
          xgmii_rxc   <= acc_rxc;
        end
        acc_rxd  <= START_WORD;
        acc_rxc  <= '1;
        lane_cnt <= LW'(1);
      end else if (word_done) begin
        xgmii_valid <= 1'b1;
        xgmii_rxd   <= merge_rxd;
        xgmii_rxc   <= merge_rxc;
        acc_rxd     <= IDLE_WORD;
        acc_rxc     <= '1;
        lane_cnt    <= '0;
      end else begin
        acc_rxd  <= merge_rxd;
        acc_rxc  <= merge_rxc;
        lane_cnt <= lane_cnt + LW'(1);
      end
    end
  end

endmodule

// File: tb/tb_gmii_xgmii_lane_packer.sv
// Table-driven bench for gmii_xgmii_lane_packer (LANES=4, FRAME_MAX_BIT_WIDTH=6).
// Expected words are hand-derived per cycle; outputs sampled 1 time unit after each rising edge.
module tb_gmii_xgmii_lane_packer;

  localparam int LANES = 4;
  localparam int FMW   = 6;

  logic         sys_clk = 1'b0;
  logic         sys_rst;
  logic         gmii_dv;
  logic         gmii_er;
  logic [7:0]   gmii_rxd;
  logic         xgmii_valid;
  logic [3:0]   xgmii_rxc;
  logic [31:0]  xgmii_rxd;
  logic [31:0]  frame_cnt;
  logic         oversize_err;

  gmii_xgmii_lane_packer #(
    .LANES               (LANES),
    .FRAME_MAX_BIT_WIDTH (FMW)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .gmii_dv      (gmii_dv),
    .gmii_er      (gmii_er),
    .gmii_rxd     (gmii_rxd),
    .xgmii_valid  (xgmii_valid),
    .xgmii_rxc    (xgmii_rxc),
    .xgmii_rxd    (xgmii_rxd),
    .frame_cnt    (frame_cnt),
    .oversize_err (oversize_err)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic        rst;
    logic        dv;
    logic        er;
    logic [7:0]  rxd;
    logic        v;
    logic [3:0]  c;
    logic [31:0] d;
    logic [31:0] fc;
    logic        ov;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

`ifdef GMII_ER_EN
  localparam logic [31:0] ER_WORD = 32'hD3FED1FB;
  localparam logic [3:0]  ER_CTL  = 4'h5;
`else
  localparam logic [31:0] ER_WORD = 32'hD3D2D1FB;
  localparam logic [3:0]  ER_CTL  = 4'h1;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic dv, input logic er, input logic [7:0] rxd,
                     input logic v, input logic [3:0] c, input logic [31:0] d,
                     input logic [31:0] fc, input logic ov);
    vec_t t;
    t.rst = rst; t.dv = dv; t.er = er; t.rxd = rxd;
    t.v = v; t.c = c; t.d = d; t.fc = fc; t.ov = ov;
    vecs.push_back(t);
  endtask

  task automatic apply(input vec_t t, input string tag);
    sys_rst  = t.rst;
    gmii_dv  = t.dv;
    gmii_er  = t.er;
    gmii_rxd = t.rxd;
    @(posedge sys_clk);
    #1;
    chk({tag, " valid"}, 32'(xgmii_valid), 32'(t.v));
    chk({tag, " frame_cnt"}, frame_cnt, t.fc);
    chk({tag, " oversize_err"}, 32'(oversize_err), 32'(t.ov));
    if (t.v || t.rst) begin
      chk({tag, " rxc"}, 32'(xgmii_rxc), 32'(t.c));
      chk({tag, " rxd"}, xgmii_rxd, t.d);
    end
  endtask

  task automatic build_table();
    logic [31:0] w;
    logic [3:0]  c;
    logic [7:0]  by;
    logic        ct;
    int          b;
    // 16 idle cycles straight after reset: all-Idle word every 4th cycle
    for (int k = 1; k <= 16; k++)
      add(0, 0, 0, 8'h00, (k % 4 == 0), 4'hF, 32'h07070707, 0, 0);
    // preamble 55x7 D5 + DE AD BE EF, SOF at lane 0
    add(0, 1, 0, 8'h55, 0, 4'h0, 32'h0, 0, 0);
    add(0, 1, 0, 8'h55, 0, 4'h0, 32'h0, 0, 0);
    add(0, 1, 0, 8'h55, 0, 4'h0, 32'h0, 0, 0);
    add(0, 1, 0, 8'h55, 1, 4'h1, 32'h555555FB, 0, 0);
    add(0, 1, 0, 8'h55, 0, 4'h0, 32'h0, 0, 0);
    add(0, 1, 0, 8'h55, 0, 4'h0, 32'h0, 0, 0);
    add(0, 1, 0, 8'h55, 0, 4'h0, 32'h0, 0, 0);
    add(0, 1, 0, 8'hD5, 1, 4'h0, 32'hD5555555, 0, 0);
    add(0, 1, 0, 8'hDE, 0, 4'h0, 32'h0, 0, 0);
    add(0, 1, 0, 8'hAD, 0, 4'h0, 32'h0, 0, 0);
    add(0, 1, 0, 8'hBE, 0, 4'h0, 32'h0, 0, 0);
    add(0, 1, 0, 8'hEF, 1, 4'h0, 32'hEFBEADDE, 0, 0);
    add(0, 0, 0, 8'h00, 0, 4'h0, 32'h0, 1, 0);
    add(0, 0, 0, 8'h00, 0, 4'h0, 32'h0, 1, 0);
    add(0, 0, 0, 8'h00, 0, 4'h0, 32'h0, 1, 0);
    add(0, 0, 0, 8'h00, 1, 4'hF, 32'h070707FD, 1, 0);
    // SOF at lane 2 flushes an all-Idle word; dv high for a single cycle
    add(0, 0, 0, 8'h00, 0, 4'h0, 32'h0, 1, 0);
    add(0, 0, 0, 8'h00, 0, 4'h0, 32'h0, 1, 0);
    add(0, 1, 0, 8'h55, 1, 4'hF, 32'h07070707, 1, 0);
    add(0, 0, 0, 8'h00, 0, 4'h0, 32'h0, 2, 0);
    add(0, 0, 0, 8'h00, 0, 4'h0, 32'h0, 2, 0);
    add(0, 0, 0, 8'h00, 1, 4'hF, 32'h0707FDFB, 2, 0);
    // last byte in lane 3 -> FD in lane 0; one idle cycle then a new SOF
    add(0, 1, 0, 8'h55, 0, 4'h0, 32'h0, 2, 0);
    add(0, 1, 0, 8'hA1, 0, 4'h0, 32'h0, 2, 0);
    add(0, 1, 0, 8'hA2, 0, 4'h0, 32'h0, 2, 0);
    add(0, 1, 0, 8'hA3, 1, 4'h1, 32'hA3A2A1FB, 2, 0);
    add(0, 1, 0, 8'hB1, 0, 4'h0, 32'h0, 2, 0);
    add(0, 1, 0, 8'hB2, 0, 4'h0, 32'h0, 2, 0);
    add(0, 1, 0, 8'hB3, 0, 4'h0, 32'h0, 2, 0);
    add(0, 1, 0, 8'hB4, 1, 4'h0, 32'hB4B3B2B1, 2, 0);
    add(0, 0, 0, 8'h00, 0, 4'h0, 32'h0, 3, 0);
    add(0, 1, 0, 8'h55, 1, 4'hF, 32'h070707FD, 3, 0);
    add(0, 1, 0, 8'hC1, 0, 4'h0, 32'h0, 3, 0);
    add(0, 0, 0, 8'h00, 0, 4'h0, 32'h0, 4, 0);
    add(0, 0, 0, 8'h00, 1, 4'hD, 32'h07FDC1FB, 4, 0);
    // receive error on the second data byte
    add(0, 1, 0, 8'h55, 0, 4'h0, 32'h0, 4, 0);
    add(0, 1, 0, 8'hD1, 0, 4'h0, 32'h0, 4, 0);
    add(0, 1, 1, 8'hD2, 0, 4'h0, 32'h0, 4, 0);
    add(0, 1, 0, 8'hD3, 1, ER_CTL, ER_WORD, 4, 0);
    add(0, 0, 0, 8'h00, 0, 4'h0, 32'h0, 5, 0);
    add(0, 0, 0, 8'h00, 0, 4'h0, 32'h0, 5, 0);
    add(0, 0, 0, 8'h00, 0, 4'h0, 32'h0, 5, 0);
    add(0, 0, 0, 8'h00, 1, 4'hF, 32'h070707FD, 5, 0);
    // 80-byte frame with a 63-byte limit: byte i carries value i, bytes past 63 become FE
    for (int i = 1; i <= 80; i++) begin
      w = '0;
      c = '0;
      for (int l = 0; l < 4; l++) begin
        b = i - 3 + l;
        if (b == 1) begin
          by = 8'hFB; ct = 1'b1;
        end else if (b <= 63) begin
          by = 8'(b); ct = 1'b0;
        end else begin
          by = 8'hFE; ct = 1'b1;
        end
        w[8*l +: 8] = by;
        c[l]        = ct;
      end
      add(0, 1, 0, (i == 1) ? 8'h55 : 8'(i), (i % 4 == 0), c, w, 5, (i == 63));
    end
    add(0, 0, 0, 8'h00, 0, 4'h0, 32'h0, 6, 0);
    add(0, 0, 0, 8'h00, 0, 4'h0, 32'h0, 6, 0);
    add(0, 0, 0, 8'h00, 0, 4'h0, 32'h0, 6, 0);
    add(0, 0, 0, 8'h00, 1, 4'hF, 32'h070707FD, 6, 0);
  endtask

  initial begin
    sys_rst  = 1'b1;
    gmii_dv  = 1'b0;
    gmii_er  = 1'b0;
    gmii_rxd = 8'h00;
    build_table();

    repeat (3) @(posedge sys_clk);
    #1;
    chk("reset valid", 32'(xgmii_valid), 32'd0);
    chk("reset rxc", 32'(xgmii_rxc), 32'hF);
    chk("reset rxd", xgmii_rxd, 32'h07070707);
    chk("reset frame_cnt", frame_cnt, 32'd0);
    chk("reset oversize_err", 32'(oversize_err), 32'd0);

    for (int i = 0; i < vecs.size(); i++)
      apply(vecs[i], $sformatf("vec%0d", i));

    // reset in the middle of a frame: partial word dropped, no FD, clean restart
    apply('{1'b0, 1'b1, 1'b0, 8'h55, 1'b0, 4'h0, 32'h0, 32'd6, 1'b0}, "mid sof");
    apply('{1'b0, 1'b1, 1'b0, 8'h11, 1'b0, 4'h0, 32'h0, 32'd6, 1'b0}, "mid b1");
    apply('{1'b0, 1'b1, 1'b0, 8'h22, 1'b0, 4'h0, 32'h0, 32'd6, 1'b0}, "mid b2");
    apply('{1'b1, 1'b1, 1'b0, 8'h33, 1'b0, 4'hF, 32'h07070707, 32'd0, 1'b0}, "mid reset");
    apply('{1'b0, 1'b1, 1'b0, 8'h55, 1'b0, 4'h0, 32'h0, 32'd0, 1'b0}, "post sof");
    apply('{1'b0, 1'b1, 1'b0, 8'hE1, 1'b0, 4'h0, 32'h0, 32'd0, 1'b0}, "post b1");
    apply('{1'b0, 1'b1, 1'b0, 8'hE2, 1'b0, 4'h0, 32'h0, 32'd0, 1'b0}, "post b2");
    apply('{1'b0, 1'b1, 1'b0, 8'hE3, 1'b1, 4'h1, 32'hE3E2E1FB, 32'd0, 1'b0}, "post w0");
    apply('{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0, 32'h0, 32'd1, 1'b0}, "post term");
    apply('{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0, 32'h0, 32'd1, 1'b0}, "post idle1");
    apply('{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0, 32'h0, 32'd1, 1'b0}, "post idle2");
    apply('{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 4'hF, 32'h070707FD, 32'd1, 1'b0}, "post w1");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
